// File: rtl/lcd_text_pkg.sv
// Shared constants, control codes and FSM encoding
// for the LCD text console.
package lcd_text_pkg;

  localparam int COLS_DEF = 60;
  localparam int ROWS_DEF = 17;

  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] FONT_BASE = 8'h20;
  localparam logic [7:0] CH_LAST   = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    CHAR_WR,
    CLR_SCREEN,
    CLR_ROW
  } state_e;

  // Glyph index with bit 7 cleared, copied onto all four byte lanes
  function automatic logic [31:0] glyph_word(input logic [7:0] c);
    logic [7:0] g;
    g    = c - FONT_BASE;
    g[7] = 1'b0;
    return {4{g}};
  endfunction

endpackage

// File: rtl/lcd_text_console_if.sv
// Byte-input handshake and text-buffer write bus
// of the LCD text console.
interface lcd_text_console_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        select;
  logic [3:0]  wstrb;
  logic [11:0] addr;
  logic [31:0] data_o;
  logic        ready;

  modport master (
    input  in_valid, in_data, ready,
    output in_ready, select, wstrb, addr, data_o
  );

  modport slave (
    output in_valid, in_data, ready,
    input  in_ready, select, wstrb, addr, data_o
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// Select/ready write engine: single cell writes and
// multi-word clears with a one-cycle gap between words.
module lcd_bus_writer #(
  parameter int RST_WORDS = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_go_i,
  input  logic [11:0] char_addr_i,
  input  logic [3:0]  char_wstrb_i,
  input  logic [31:0] char_data_i,
  input  logic        clr_go_i,
  input  logic [7:0]  clr_words_i,
  input  logic        ready_i,
  output logic        select_o,
  output logic [11:0] addr_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] data_o,
  output logic        done_o
);

  logic        sel_q;
  logic        pend_q;
  logic [11:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] data_q;
  logic [7:0]  left_q;

  // Reset leaves a full-screen clear pending; clear words
  // are raised one cycle after the previous completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      pend_q  <= 1'b1;
      addr_q  <= '0;
      wstrb_q <= '0;
      data_q  <= '0;
      left_q  <= 8'(RST_WORDS - 1);
    end else if (char_go_i) begin
      sel_q   <= 1'b1;
      pend_q  <= 1'b0;
      addr_q  <= char_addr_i;
      wstrb_q <= char_wstrb_i;
      data_q  <= char_data_i;
      left_q  <= '0;
    end else if (clr_go_i) begin
      sel_q   <= 1'b0;
      pend_q  <= 1'b1;
      addr_q  <= '0;
      left_q  <= clr_words_i - 8'd1;
    end else if (sel_q && ready_i) begin
      sel_q <= 1'b0;
      if (left_q != 8'd0) begin
        pend_q <= 1'b1;
        addr_q <= addr_q + 12'd4;
        left_q <= left_q - 8'd1;
      end
    end else if (pend_q) begin
      sel_q   <= 1'b1;
      pend_q  <= 1'b0;
      wstrb_q <= 4'hF;
      data_q  <= '0;
    end
  end

  assign select_o = sel_q;
  assign addr_o   = addr_q;
  assign wstrb_o  = wstrb_q;
  assign data_o   = data_q;
  assign done_o   = sel_q & ready_i & (left_q == 8'd0);

endmodule

// File: rtl/lcd_text_console.sv
// Text console: decodes ASCII bytes into cursor moves
// and character-cell writes on the text buffer bus.
module lcd_text_console
  import lcd_text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_text_console_if.master bus,
  output logic [5:0]         cursor_col,
  output logic [4:0]         cursor_row,
  output logic               busy
);

  localparam int SCR_WORDS = (COLS * ROWS + 3) / 4;
  localparam int ROW_WORDS = (COLS + 3) / 4;

  state_e      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        char_go, clr_go, done;
  logic [7:0]  clr_words;
  logic [11:0] offset;
  logic        printable, last_col, last_row;

  assign printable = (bus.in_data >= FONT_BASE)
                   && (bus.in_data <= CH_LAST);
  assign last_col  = col_q == 6'(COLS - 1);
  assign last_row  = row_q == 5'(ROWS - 1);
  assign offset    = 12'(row_q) * 12'(COLS) + 12'(col_q);

  // State and cursor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_SCREEN;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Byte decode, cursor advance and clear sequencing
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    char_go   = 1'b0;
    clr_go    = 1'b0;
    clr_words = 8'(ROW_WORDS);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          unique case (1'b1)
            printable: begin
              char_go = 1'b1;
              state_d = CHAR_WR;
            end
            bus.in_data == CH_LF: begin
              col_d = '0;
              if (last_row) begin
                row_d   = '0;
                clr_go  = 1'b1;
                state_d = CLR_ROW;
              end else begin
                row_d = row_q + 5'd1;
              end
            end
            bus.in_data == CH_CR: col_d = '0;
            bus.in_data == CH_BS: begin
              if (col_q != 6'd0) col_d = col_q - 6'd1;
            end
            bus.in_data == CH_FF: begin
              col_d     = '0;
              row_d     = '0;
              clr_go    = 1'b1;
              clr_words = 8'(SCR_WORDS);
              state_d   = CLR_SCREEN;
            end
            default: ;
          endcase
        end
      end
      CHAR_WR: begin
        if (done) begin
          state_d = IDLE;
          if (!last_col) begin
            col_d = col_q + 6'd1;
          end else begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              clr_go  = 1'b1;
              state_d = CLR_ROW;
            end else begin
              row_d = row_q + 5'd1;
            end
          end
        end
      end
      CLR_SCREEN, CLR_ROW: begin
        if (done) state_d = IDLE;
      end
    endcase
  end

  lcd_bus_writer #(
    .RST_WORDS (SCR_WORDS)
  ) u_writer (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_go_i    (char_go),
    .char_addr_i  (offset),
    .char_wstrb_i (4'b0001 << offset[1:0]),
    .char_data_i  (glyph_word(bus.in_data)),
    .clr_go_i     (clr_go),
    .clr_words_i  (clr_words),
    .ready_i      (bus.ready),
    .select_o     (bus.select),
    .addr_o       (bus.addr),
    .wstrb_o      (bus.wstrb),
    .data_o       (bus.data_o),
    .done_o       (done)
  );

  assign bus.in_ready = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;

endmodule

// File: tb/tb_lcd_text_console.sv
// Self-checking bench for lcd_text_console: vector table,
// corner sequences and random bytes against a cursor model.
module tb_lcd_text_console;

  localparam int COLS = 60;
  localparam int ROWS = 17;
  localparam int SCRW = (COLS * ROWS + 3) / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] ccol;
  logic [4:0] crow;
  logic busy;

  always #5 clk = ~clk;

  lcd_text_console_if bus();

  lcd_text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cursor_col (ccol),
    .cursor_row (crow),
    .busy       (busy)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [7:0]  b;
    int          col;
    int          row;
    int          nwr;
    logic [11:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } vec_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  vec_t tv[18];

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;
  bit hold = 1'b0;
  bit spur = 1'b0;
  int stab_bad = 0;
  int gap_bad = 0;
  int mcol = 0;
  int mrow = 0;

  task automatic check(string nm, logic [47:0] act, logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Bus slave: ready pulses lat cycles after select rises
  initial begin
    int age;
    age = 0;
    bus.ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.select !== 1'b1) begin
        age = 0;
        bus.ready = spur && ($urandom_range(0, 3) == 0);
      end else begin
        age++;
        bus.ready = !hold && (age == lat + 1);
      end
    end
  end

  // Monitor: log completed writes, check hold and gap rules
  initial begin
    wr_t cur, first;
    bit seen, prev_done;
    seen = 0;
    prev_done = 0;
    first = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        seen = 0;
        prev_done = 0;
      end else begin
        if (bus.select && prev_done) gap_bad++;
        prev_done = 0;
        if (bus.select) begin
          cur = {bus.addr, bus.wstrb, bus.data_o};
          if (!seen) first = cur;
          seen = 1;
          if (cur != first) stab_bad++;
          if (bus.ready) begin
            got_q.push_back(cur);
            seen = 0;
            prev_done = 1;
          end
        end else begin
          seen = 0;
        end
      end
    end
  end

  task automatic model_wrap();
    mrow++;
    if (mrow == ROWS) begin
      mrow = 0;
      for (int i = 0; i < COLS / 4; i++)
        exp_q.push_back(wr_t'{12'(4 * i), 4'hF, 32'h0});
    end
  endtask

  // Reference behaviour of one accepted byte
  task automatic model_byte(input logic [7:0] b);
    int off;
    logic [7:0] g;
    if (b >= 8'h20 && b <= 8'h7E) begin
      off = mrow * COLS + mcol;
      g = b - 8'h20;
      exp_q.push_back(wr_t'{12'(off), 4'(1 << (off % 4)), {4{g}}});
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        model_wrap();
      end
    end else if (b == 8'h0A) begin
      mcol = 0;
      model_wrap();
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      mcol = 0;
      mrow = 0;
      for (int i = 0; i < SCRW; i++)
        exp_q.push_back(wr_t'{12'(4 * i), 4'hF, 32'h0});
    end
  endtask

  task automatic wait_idle(string nm, output int n);
    n = 0;
    while (!(bus.in_ready === 1'b1 && busy === 1'b0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check({nm, "_idle_timeout"}, 48'(busy), 48'(0));
  endtask

  // Offer one byte at a negedge, then wait until idle again
  task automatic send_byte(input logic [7:0] b, output int n);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("accept_timeout", 48'(bus.in_ready), 48'(1));
      n = 0;
    end else begin
      model_byte(b);
      bus.in_valid = 1'b1;
      bus.in_data = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
      wait_idle("send", n);
    end
  endtask

  task automatic cmp_queue(string nm);
    int nm_ok;
    nm_ok = 0;
    check({nm, "_count"}, 48'(got_q.size()), 48'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] === exp_q[i]) nm_ok++;
    check({nm, "_match"}, 48'(nm_ok), 48'(exp_q.size()));
    check({nm, "_col"}, 48'(ccol), 48'(mcol));
    check({nm, "_row"}, 48'(crow), 48'(mrow));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [7:0] b;

    tv[0]  = '{8'h61, 1, 0, 1, 12'h000, 4'h1, 32'h41414141};
    tv[1]  = '{8'h62, 2, 0, 1, 12'h001, 4'h2, 32'h42424242};
    tv[2]  = '{8'h0D, 0, 0, 0, 12'h0, 4'h0, 32'h0};
    tv[3]  = '{8'h08, 0, 0, 0, 12'h0, 4'h0, 32'h0};
    tv[4]  = '{8'h07, 0, 0, 0, 12'h0, 4'h0, 32'h0};
    tv[5]  = '{8'h20, 1, 0, 1, 12'h000, 4'h1, 32'h00000000};
    tv[6]  = '{8'h7E, 2, 0, 1, 12'h001, 4'h2, 32'h5E5E5E5E};
    tv[7]  = '{8'h08, 1, 0, 0, 12'h0, 4'h0, 32'h0};
    tv[8]  = '{8'h7F, 1, 0, 0, 12'h0, 4'h0, 32'h0};
    tv[9]  = '{8'h30, 2, 0, 1, 12'h001, 4'h2, 32'h10101010};
    tv[10] = '{8'h21, 3, 0, 1, 12'h002, 4'h4, 32'h01010101};
    tv[11] = '{8'h22, 4, 0, 1, 12'h003, 4'h8, 32'h02020202};
    tv[12] = '{8'h23, 5, 0, 1, 12'h004, 4'h1, 32'h03030303};
    tv[13] = '{8'h41, 6, 0, 1, 12'h005, 4'h2, 32'h21212121};
    tv[14] = '{8'h0A, 0, 1, 0, 12'h0, 4'h0, 32'h0};
    tv[15] = '{8'h42, 1, 1, 1, 12'h03C, 4'h1, 32'h22222222};
    tv[16] = '{8'h0C, 0, 0, SCRW, 12'h3F8, 4'hF, 32'h0};
    tv[17] = '{8'h80, 0, 0, 0, 12'h0, 4'h0, 32'h0};

    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_select", 48'(bus.select), 48'(0));
    check("rst_wstrb", 48'(bus.wstrb), 48'(0));
    check("rst_addr", 48'(bus.addr), 48'(0));
    check("rst_data", 48'(bus.data_o), 48'(0));
    check("rst_in_ready", 48'(bus.in_ready), 48'(0));
    check("rst_busy", 48'(busy), 48'(1));
    check("rst_col", 48'(ccol), 48'(0));
    check("rst_row", 48'(crow), 48'(0));

    rst_n = 1'b1;
    model_byte(8'h0C);
    wait_idle("boot", n);
    check("boot_in_ready", 48'(bus.in_ready), 48'(1));
    cmp_queue("boot_clear");

    foreach (tv[i]) begin
      send_byte(tv[i].b, n);
      check($sformatf("vec%0d_col", i), 48'(ccol), 48'(tv[i].col));
      check($sformatf("vec%0d_row", i), 48'(crow), 48'(tv[i].row));
      check($sformatf("vec%0d_nwr", i), 48'(got_q.size()), 48'(tv[i].nwr));
      if (tv[i].nwr > 0 && got_q.size() > 0) begin
        check($sformatf("vec%0d_addr", i),
              48'(got_q[got_q.size()-1].a), 48'(tv[i].a));
        check($sformatf("vec%0d_wstrb", i),
              48'(got_q[got_q.size()-1].s), 48'(tv[i].s));
        check($sformatf("vec%0d_data", i),
              48'(got_q[got_q.size()-1].d), 48'(tv[i].d));
      end
      got_q.delete();
      exp_q.delete();
    end

    send_byte(8'h0C, n);
    cmp_queue("ff_clear");
    for (int i = 0; i < COLS; i++) begin
      send_byte(8'h78, n);
      if (i == 0) check("throughput_gap", 48'(n), 48'(2));
    end
    if (got_q.size() > 0) begin
      check("row0_last_addr", 48'(got_q[got_q.size()-1].a), 48'(59));
      check("row0_last_wstrb", 48'(got_q[got_q.size()-1].s), 48'(4'b1000));
    end
    check("row0_wrap_col", 48'(ccol), 48'(0));
    check("row0_wrap_row", 48'(crow), 48'(1));
    cmp_queue("row0_fill");

    for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A, n);
    cmp_queue("lf_to_last");
    send_byte(8'h0A, n);
    @(negedge clk);
    check("lf_wrap_busy", 48'(busy), 48'(0));
    cmp_queue("lf_wrap_clear");

    for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, n);
    for (int i = 0; i < COLS; i++) send_byte(8'h4D, n);
    cmp_queue("colwrap_last_row");

    send_byte(8'h51, n);
    send_byte(8'h52, n);
    cmp_queue("pre_reset");
    hold = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("held_select", 48'(bus.select), 48'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_select", 48'(bus.select), 48'(0));
    check("mid_rst_wstrb", 48'(bus.wstrb), 48'(0));
    check("mid_rst_addr", 48'(bus.addr), 48'(0));
    check("mid_rst_data", 48'(bus.data_o), 48'(0));
    check("mid_rst_in_ready", 48'(bus.in_ready), 48'(0));
    check("mid_rst_col", 48'(ccol), 48'(0));
    @(negedge clk);
    hold = 1'b0;
    got_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    mcol = 0;
    mrow = 0;
    model_byte(8'h0C);
    wait_idle("reclear", n);
    cmp_queue("reset_reclear");

    spur = 1'b1;
    for (int k = 0; k < 400; k++) begin
      lat = $urandom_range(1, 3);
      r = $urandom_range(0, 99);
      if (r < 70) b = 8'($urandom_range(32, 126));
      else if (r < 80) b = 8'h0A;
      else if (r < 85) b = 8'h0D;
      else if (r < 93) b = 8'h08;
      else if (r < 94) b = 8'h0C;
      else if (r[0]) b = 8'($urandom_range(128, 255));
      else b = 8'h1B;
      send_byte(b, n);
      cmp_queue($sformatf("rnd%0d", k));
    end
    spur = 1'b0;

    check("select_hold_stable", 48'(stab_bad), 48'(0));
    check("select_gap", 48'(gap_bad), 48'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_text_console.md
LCD_TEXT_CONSOLE -- requirements
Module: lcd_text_console

Interface
REQ-001 SHALL have parameter COLS, default 60, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 17, meaning text rows per screen.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, asserted when a byte is offered.
REQ-006 SHALL have port in_data, input, 8, ASCII byte.
REQ-007 SHALL have port in_ready, output, 1, console accepts the byte this cycle.
REQ-008 SHALL have port select, output, 1, bus write request to the text buffer.
REQ-009 SHALL have port wstrb, output, 4, byte-lane enables.
REQ-010 SHALL have port addr, output, 12, byte address of the cell.
REQ-011 SHALL have port data_o, output, 32, write data.
REQ-012 SHALL have port ready, input, 1, one-cycle bus completion pulse.
REQ-013 SHALL have port cursor_col, output, 6, current column.
REQ-014 SHALL have port cursor_row, output, 5, current row.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, CHAR_WR, CLR_SCREEN and CLR_ROW; in_ready = 1 only in IDLE.
REQ-017 SHALL accept a byte on in_valid & in_ready and take the decode action in the same edge.
REQ-018 SHALL treat a printable byte 0x20..0x7E as follows:
- go to CHAR_WR;
- cell offset = row*COLS + col, 0..1019;
- addr = offset;
- wstrb = 4'b0001 << offset[1:0];
- data_o = byte (in_data - 0x20, bit7 = 0) replicated on all four lanes.
REQ-019 SHALL hold select, addr, wstrb and data_o stable from the cycle after acceptance until ready is sampled high, then drop select in that same edge.
REQ-020 SHALL advance the cursor after a completed character write: col+1, or col = 0 and row+1 when col = COLS-1.
REQ-021 SHALL handle 0x0A (LF) with col = 0 and row+1, with no bus write.
REQ-022 SHALL handle 0x0D (CR) with col = 0 and no bus write.
REQ-023 SHALL handle 0x08 (BS) with col-1 if col > 0, else no change, and no bus write.
REQ-024 SHALL handle 0x0C (FF) by entering CLR_SCREEN and setting the cursor to (0,0).
REQ-025 SHALL ignore all other bytes: accept them, with no state change.
REQ-026 SHALL wrap the row when it would pass ROWS-1 (by LF or by column wrap):
- row = 0;
- enter CLR_ROW;
- write 15 words at addr = 0,4,...,56 with wstrb = 4'hF and data_o = 0 (space);
- return to IDLE.
REQ-027 SHALL, in CLR_SCREEN, write 255 words at addr 0..1016 step 4, with wstrb = 4'hF and data_o = 0, then return to IDLE.
REQ-028 SHALL deassert select for at least one cycle between consecutive bus writes.
REQ-029 SHALL have a throughput of one character per 3 cycles when ready returns 1 cycle after select.
REQ-030 SHALL ignore ready while select = 0.

Reset
REQ-031 SHALL, on reset assertion, immediately force:
- select = 0, wstrb = 0, addr = 0, data_o = 0;
- cursor = (0,0);
- in_ready = 0;
- an in-flight write is abandoned.
REQ-032 SHALL leave reset in CLR_SCREEN (busy = 1), because the buffer has no hardware reset; IDLE follows after the 255 writes.

Structure
REQ-033 SHALL place COLS/ROWS defaults, control codes (LF, CR, BS, FF), FONT_BASE = 0x20 and the state encoding in shared package lcd_text_pkg.
REQ-034 SHALL instantiate one sub-module, lcd_bus_writer, holding the select/ready handshake and the word-clear sequencing counter.

Verification
REQ-035 SHALL verify: after reset, bus model with ready at select+1 -> 255 writes addr 0..0x3F8 data 0, then in_ready = 1.
REQ-036 SHALL verify: "A" at cursor (0,5) -> addr 0x005, wstrb 4'b0010, data_o 0x21212121, cursor (0,6).
REQ-037 SHALL verify: 60 printable bytes at row 0 -> last write at addr 59 wstrb 4'b1000, then cursor (1,0).
REQ-038 SHALL verify: LF at row 16 -> 15 writes addr 0..56 data 0, cursor (0,0), busy low afterwards.
REQ-039 SHALL verify: BS at col 0 -> no write, cursor unchanged; 0x07 -> accepted, no write.
REQ-040 SHALL verify: rst_n low while select is held with ready withheld -> select = 0 within the reset cycle, then a full clear restarts.
